// File: rtl/cal_tpsram_pkg.sv
// Shared types and elaboration helpers for the calibration two-port SRAM.
// Contents:
//   state_e        clear-sequencer states (ST_INIT fills the array, ST_IDLE serves user traffic)
//   clog2_f        address-width helper, never returns less than 1
//   rd_latency_ok  legal read-latency check used by the top-level parameter guard
package cal_tpsram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_IDLE = 1'b1
   } state_e;

   localparam int RD_LATENCY_MIN = 1;
   localparam int RD_LATENCY_MAX = 2;

   function automatic int clog2_f(input int value);
      int w;
      w = 0;
      while ((1 << w) < value) w++;
      return (w < 1) ? 1 : w;
   endfunction

   function automatic bit rd_latency_ok(input int lat);
      return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/cal_tpsram_array.sv
// Plain DEPTH x DATA_W one-write/one-read array with a registered read port.
// A same-edge write and read to one address returns the old word.
// Ports:
//   clk_i    clock (rising edge)
//   we_i     write enable; waddr_i / wdata_i  write address / data
//   re_i     read enable;  raddr_i             read address
//   rdata_o  registered read data, updated only on cycles with re_i=1
// Callers keep both addresses below DEPTH.
module cal_tpsram_array #(
   parameter int DATA_W = 36,
   parameter int DEPTH  = 512,
   parameter int ADDR_W = 9
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // NOTE: the array and its read register carry no reset so they map onto block RAM;
   // contents are initialised by the clear sequencer in the top level instead.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/cal_tpsram_param.sv
// Parametrised single-clock two-port SRAM for calibration buffers, with a hardware
// clear sequencer, read-valid pipeline, optional output register and write-to-read
// forwarding on same-address collisions.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   w_en_i/w_addr_i/w_data_i  write strobe, address, data (addresses >= DEPTH dropped)
//   r_en_i/r_addr_i        read strobe, address (addresses >= DEPTH return 0)
//   r_data_o, r_valid_o    read result RD_LATENCY cycles after an accepted read
//   init_req_i             one-cycle pulse starting a clear sequence
//   init_busy_o            clear in progress; user reads and writes are ignored
module cal_tpsram_param
   import cal_tpsram_pkg::*;
#(
   parameter int                DATA_W     = 36,
   parameter int                DEPTH      = 512,
   parameter int                ADDR_W     = clog2_f(DEPTH),
   parameter int                RD_LATENCY = 2,
   parameter int                FWD_EN     = 1,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              w_en_i,
   input  logic [ADDR_W-1:0] w_addr_i,
   input  logic [DATA_W-1:0] w_data_i,
   input  logic              r_en_i,
   input  logic [ADDR_W-1:0] r_addr_i,
   output logic [DATA_W-1:0] r_data_o,
   output logic              r_valid_o,
   input  logic              init_req_i,
   output logic              init_busy_o
);

   if (!rd_latency_ok(RD_LATENCY) || DEPTH < 2 || DATA_W < 1 || DATA_W > 72) begin : g_param_err
      $error("cal_tpsram_param: illegal RD_LATENCY, DEPTH or DATA_W");
   end

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              idle;
   logic              w_ok;
   logic              r_acc;
   logic              r_in_range;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_waddr;
   logic [DATA_W-1:0] arr_wdata;
   logic [DATA_W-1:0] arr_rdata;

   // Read stage 1: qualifiers captured with each accepted read.
   logic              v1_q;
   logic              zero1_q;
   logic              fwd1_q;
   logic [DATA_W-1:0] fwd_data1_q;
   logic [DATA_W-1:0] data1;

   assign idle        = (state_q == ST_IDLE);
   assign init_busy_o = ~idle;
   assign w_ok        = idle & w_en_i & ({1'b0, w_addr_i} < DEPTH_C);
   assign r_acc       = idle & r_en_i;
   assign r_in_range  = ({1'b0, r_addr_i} < DEPTH_C);

   // The clear sequencer owns the write port while busy.
   assign arr_we    = ~idle | w_ok;
   assign arr_waddr = idle ? w_addr_i : ptr_q;
   assign arr_wdata = idle ? w_data_i : INIT_VALUE;

   // NOTE: every combinational output gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_INIT: begin
            if (ptr_q == LAST_C) begin
               state_d = ST_IDLE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + ADDR_W'(1);
            end
         end
         ST_IDLE: begin
            if (init_req_i) state_d = ST_INIT;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops sample
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   cal_tpsram_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk_i   (clk_i),
      .we_i    (arr_we),
      .waddr_i (arr_waddr),
      .wdata_i (arr_wdata),
      .re_i    (r_acc & r_in_range),
      .raddr_i (r_addr_i),
      .rdata_o (arr_rdata)
   );

   // Qualifiers only change on accepted reads, so data1 holds between reads.
   // zero1_q resets to 1 so the unregistered (latency 1) output reads 0 out of reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         v1_q        <= 1'b0;
         zero1_q     <= 1'b1;
         fwd1_q      <= 1'b0;
         fwd_data1_q <= '0;
      end else begin
         v1_q <= r_acc;
         if (r_acc) begin
            zero1_q     <= ~r_in_range;
            fwd1_q      <= (FWD_EN != 0) && w_ok && r_in_range && (w_addr_i == r_addr_i);
            fwd_data1_q <= w_data_i;
         end
      end
   end

   assign data1 = zero1_q ? '0 : (fwd1_q ? fwd_data1_q : arr_rdata);

   if (RD_LATENCY == 2) begin : g_out_reg
      logic [DATA_W-1:0] r_data_q;
      logic              v2_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_data_q <= '0;
            v2_q     <= 1'b0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) r_data_q <= data1;
         end
      end

      assign r_data_o  = r_data_q;
      assign r_valid_o = v2_q;
   end else begin : g_out_direct
      assign r_data_o  = data1;
      assign r_valid_o = v1_q;
   end

endmodule

// File: tb/tb_cal_tpsram_param.sv
// Directed bench for cal_tpsram_param. Main instance: 512x36, latency 2, forwarding on.
// Small instance: 300x20, latency 1, forwarding off.
module tb_cal_tpsram_param;

   localparam int            DW     = 36;
   localparam int            DP     = 512;
   localparam int            AW     = 9;
   localparam int            LAT    = 2;
   localparam logic [DW-1:0] INIT_M = 36'h5_A5A5_C3C3;

   localparam int             SDW    = 20;
   localparam int             SDP    = 300;
   localparam int             SAW    = 9;
   localparam logic [SDW-1:0] INIT_S = 20'h3C3C3;

   logic          clk = 1'b0;
   logic          rst;

   logic          w_en, r_en, init_req;
   logic [AW-1:0] w_addr, r_addr;
   logic [DW-1:0] w_data, r_data;
   logic          r_valid, init_busy;

   logic           s_w_en, s_r_en, s_init_req;
   logic [SAW-1:0] s_w_addr, s_r_addr;
   logic [SDW-1:0] s_w_data, s_r_data;
   logic           s_r_valid, s_init_busy;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] ref_mem [DP];

   cal_tpsram_param #(
      .DATA_W(DW), .DEPTH(DP), .RD_LATENCY(LAT), .FWD_EN(1), .INIT_VALUE(INIT_M)
   ) u_dut (
      .clk_i(clk), .rst_i(rst),
      .w_en_i(w_en), .w_addr_i(w_addr), .w_data_i(w_data),
      .r_en_i(r_en), .r_addr_i(r_addr),
      .r_data_o(r_data), .r_valid_o(r_valid),
      .init_req_i(init_req), .init_busy_o(init_busy)
   );

   cal_tpsram_param #(
      .DATA_W(SDW), .DEPTH(SDP), .RD_LATENCY(1), .FWD_EN(0), .INIT_VALUE(INIT_S)
   ) u_small (
      .clk_i(clk), .rst_i(rst),
      .w_en_i(s_w_en), .w_addr_i(s_w_addr), .w_data_i(s_w_data),
      .r_en_i(s_r_en), .r_addr_i(s_r_addr),
      .r_data_o(s_r_data), .r_valid_o(s_r_valid),
      .init_req_i(s_init_req), .init_busy_o(s_init_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      w_en = 1'b0; w_addr = '0; w_data = '0; r_en = 1'b0; r_addr = '0; init_req = 1'b0;
      s_w_en = 1'b0; s_w_addr = '0; s_w_data = '0; s_r_en = 1'b0; s_r_addr = '0; s_init_req = 1'b0;
   endtask

   task automatic fill_ref(input logic [DW-1:0] v);
      for (int i = 0; i < DP; i++) ref_mem[i] = v;
   endtask

   // Reads 0..DP-1 back to back on the main instance and tallies timing/data deviations
   // against ref_mem; callers compare the tallies.
   task automatic stream_read(output int n_valid, output int n_bad, output int first_bad);
      int j;
      n_valid = 0; n_bad = 0; first_bad = -1;
      for (int i = 0; i < DP + LAT; i++) begin
         if (i < DP) begin r_en = 1'b1; r_addr = AW'(i); end
         else r_en = 1'b0;
         tick();
         j = i - (LAT - 1);
         if (r_valid === 1'b1) n_valid++;
         if (r_valid !== ((j >= 0) && (j < DP))) begin
            n_bad++;
            if (first_bad < 0) first_bad = j;
         end else if ((j >= 0) && (j < DP) && (r_data !== ref_mem[j])) begin
            n_bad++;
            if (first_bad < 0) first_bad = j;
         end
      end
      r_en = 1'b0;
   endtask

   task automatic test_reset();
      int n_m, n_s, guard;
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL reset_r_valid got=%b exp=0", r_valid); end
      checks++; if (r_data !== '0) begin failures++; $display("FAIL reset_r_data got=%h exp=0", r_data); end
      checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", init_busy); end
      checks++; if (s_r_data !== '0) begin failures++; $display("FAIL reset_small_r_data got=%h exp=0", s_r_data); end
      checks++; if (s_r_valid !== 1'b0) begin failures++; $display("FAIL reset_small_r_valid got=%b exp=0", s_r_valid); end
      rst = 1'b0;
      n_m = 0; n_s = 0; guard = 0;
      while ((init_busy !== 1'b0 || s_init_busy !== 1'b0) && guard < 2000) begin
         if (init_busy !== 1'b0) n_m++;
         if (s_init_busy !== 1'b0) n_s++;
         tick();
         guard++;
      end
      checks++; if (n_m != DP) begin failures++; $display("FAIL reset_busy_cycles got=%0d exp=%0d", n_m, DP); end
      checks++; if (n_s != SDP) begin failures++; $display("FAIL reset_small_busy_cycles got=%0d exp=%0d", n_s, SDP); end
      fill_ref(INIT_M);
   endtask

   task automatic test_init_contents();
      int nv, nb, fb;
      stream_read(nv, nb, fb);
      checks++; if (nv != DP) begin failures++; $display("FAIL init_valid_count got=%0d exp=%0d", nv, DP); end
      checks++; if (nb != 0) begin failures++; $display("FAIL init_contents bad=%0d exp=0 first_addr=%0d", nb, fb); end
   endtask

   task automatic test_write_read();
      int nv, nb, fb;
      w_en = 1'b1; w_addr = 9'd5; w_data = 36'h1_2345_6789;
      tick();
      w_en = 1'b0; r_en = 1'b1; r_addr = 9'd5;
      tick();
      r_en = 1'b0;
      checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_early_valid got=%b exp=0", r_valid); end
      tick();
      checks++; if (r_valid !== 1'b1) begin failures++; $display("FAIL wr_rd_valid got=%b exp=1", r_valid); end
      checks++; if (r_data !== 36'h1_2345_6789) begin failures++; $display("FAIL wr_rd_data got=%h exp=123456789", r_data); end
      tick();
      checks++; if (r_valid !== 1'b0) begin failures++; $display("FAIL wr_rd_valid_drop got=%b exp=0", r_valid); end
      checks++; if (r_data !== 36'h1_2345_6789) begin failures++; $display("FAIL wr_rd_hold got=%h exp=123456789", r_data); end
      ref_mem[5] = 36'h1_2345_6789;
      stream_read(nv, nb, fb);
      checks++; if (nv != DP) begin failures++; $display("FAIL b2b_valid_count got=%0d exp=%0d", nv, DP); end
      checks++; if (nb != 0) begin failures++; $display("FAIL b2b_stream bad=%0d exp=0 first_addr=%0d", nb, fb); end
   endtask

   task automatic test_collision();
      // Main instance forwards the new word.
      w_en = 1'b1; w_addr = 9'd7; w_data = 36'h0AA;
      tick();
      w_data = 36'h155; r_en = 1'b1; r_addr = 9'd7;
      tick();
      w_en = 1'b0; r_en = 1'b0;
      tick();
      checks++; if (r_valid !== 1'b1 || r_data !== 36'h155) begin
         failures++; $display("FAIL coll_fwd got=%h/%b exp=155/1", r_data, r_valid); end
      ref_mem[7] = 36'h155;
      // Small instance returns the old word.
      s_w_en = 1'b1; s_w_addr = 9'd7; s_w_data = 20'h000AA;
      tick();
      s_w_data = 20'h00155; s_r_en = 1'b1; s_r_addr = 9'd7;
      tick();
      s_w_en = 1'b0; s_r_en = 1'b0;
      checks++; if (s_r_valid !== 1'b1 || s_r_data !== 20'h000AA) begin
         failures++; $display("FAIL coll_nofwd got=%h/%b exp=000aa/1", s_r_data, s_r_valid); end
      s_r_en = 1'b1;
      tick();
      s_r_en = 1'b0;
      checks++; if (s_r_data !== 20'h00155) begin
         failures++; $display("FAIL coll_nofwd_after got=%h exp=00155", s_r_data); end
      tick();
   endtask

   task automatic test_reset_mid();
      int n, nv, nb, fb;
      logic seen_valid;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (200) tick();
      rst = 1'b1;
      #1;
      checks++; if (init_busy !== 1'b1 || r_valid !== 1'b0) begin
         failures++; $display("FAIL mid_reset_state got=%b/%b exp=1/0", init_busy, r_valid); end
      tick();
      rst = 1'b0;
      n = 0; seen_valid = 1'b0;
      while (init_busy !== 1'b0 && n < 2000) begin
         if (n == 10) begin
            w_en = 1'b1; w_addr = 9'd3; w_data = 36'hFFF; r_en = 1'b1; r_addr = 9'd3;
         end else begin
            w_en = 1'b0; r_en = 1'b0;
         end
         if (r_valid !== 1'b0) seen_valid = 1'b1;
         tick();
         n++;
      end
      w_en = 1'b0; r_en = 1'b0;
      checks++; if (n != DP) begin failures++; $display("FAIL mid_reset_busy_cycles got=%0d exp=%0d", n, DP); end
      checks++; if (seen_valid !== 1'b0) begin failures++; $display("FAIL init_read_valid got=%b exp=0", seen_valid); end
      fill_ref(INIT_M);
      stream_read(nv, nb, fb);
      checks++; if (nb != 0) begin failures++; $display("FAIL mid_reset_contents bad=%0d exp=0 first_addr=%0d", nb, fb); end
   endtask

   task automatic test_init_req();
      int n, nv, nb, fb;
      for (int i = 0; i < DP; i++) begin
         w_en = 1'b1; w_addr = AW'(i); w_data = 36'hFFF;
         tick();
      end
      w_en = 1'b0;
      fill_ref(36'hFFF);
      r_en = 1'b1; r_addr = 9'd9;
      tick();
      r_en = 1'b0; init_req = 1'b1;
      tick();
      init_req = 1'b0;
      checks++; if (r_valid !== 1'b1 || r_data !== 36'hFFF) begin
         failures++; $display("FAIL inflight_read got=%h/%b exp=fff/1", r_data, r_valid); end
      checks++; if (init_busy !== 1'b1) begin failures++; $display("FAIL init_req_busy got=%b exp=1", init_busy); end
      n = 0;
      while (init_busy !== 1'b0 && n < 2000) begin
         init_req = (n == 100);
         tick();
         n++;
      end
      init_req = 1'b0;
      checks++; if (n != DP) begin failures++; $display("FAIL init_req_busy_cycles got=%0d exp=%0d", n, DP); end
      fill_ref(INIT_M);
      stream_read(nv, nb, fb);
      checks++; if (nb != 0) begin failures++; $display("FAIL init_req_contents bad=%0d exp=0 first_addr=%0d", nb, fb); end
   endtask

   task automatic test_small_bounds();
      checks++; if (s_init_busy !== 1'b0) begin failures++; $display("FAIL small_busy got=%b exp=0", s_init_busy); end
      s_w_en = 1'b1; s_w_addr = 9'd299; s_w_data = 20'hABCDE;
      tick();
      s_w_addr = 9'd310; s_w_data = 20'h12345;
      tick();
      s_w_en = 1'b0;
      s_r_en = 1'b1; s_r_addr = 9'd299;
      tick();
      s_r_en = 1'b0;
      checks++; if (s_r_valid !== 1'b1 || s_r_data !== 20'hABCDE) begin
         failures++; $display("FAIL small_last_addr got=%h/%b exp=abcde/1", s_r_data, s_r_valid); end
      tick();
      checks++; if (s_r_valid !== 1'b0 || s_r_data !== 20'hABCDE) begin
         failures++; $display("FAIL small_hold got=%h/%b exp=abcde/0", s_r_data, s_r_valid); end
      s_r_en = 1'b1; s_r_addr = 9'd310;
      tick();
      s_r_en = 1'b0;
      checks++; if (s_r_valid !== 1'b1 || s_r_data !== 20'h0) begin
         failures++; $display("FAIL small_oob_read got=%h/%b exp=00000/1", s_r_data, s_r_valid); end
      s_r_en = 1'b1; s_r_addr = 9'd0;
      tick();
      s_r_en = 1'b0;
      checks++; if (s_r_valid !== 1'b1 || s_r_data !== INIT_S) begin
         failures++; $display("FAIL small_init_word got=%h/%b exp=%h/1", s_r_data, s_r_valid, INIT_S); end
      tick();
   endtask

   initial begin
      test_reset();
      test_init_contents();
      test_write_read();
      test_collision();
      test_reset_mid();
      test_init_req();
      test_small_bounds();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
